// File: rtl/mac_array_seq_ctrl.sv
// West-edge instruction and feeder-strobe sequencer for the mac_tile systolic array.
// Runs weight-stationary (load/exec/drain) and output-stationary (load/exec/drain/flush) jobs.
module mac_array_seq_ctrl #(
   parameter int unsigned row    = 8,
   parameter int unsigned col    = 8,
   parameter int unsigned len_bw = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              is_os_in,
   input  logic              act_2b_in,
   input  logic [len_bw-1:0] exec_len,
   output logic [2:0]        inst_w,
   output logic              is_os,
   output logic              act_2b_mode,
   output logic              l0_rd,
   output logic              psum_rd,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW_LOAD  = $clog2(2 * col + 1);
   localparam int unsigned CW_SKEW  = $clog2(row + col + 1);
   localparam int unsigned CW_LS    = (CW_LOAD > CW_SKEW) ? CW_LOAD : CW_SKEW;
   localparam int unsigned CNT_W    = (len_bw > CW_LS) ? len_bw : CW_LS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_DRAIN = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                os_q, os_d;
   logic                a2b_q, a2b_d;
   logic [len_bw-1:0]   len_q, len_d;
   logic [2:0]          inst_q, inst_d;
   logic                l0_q, l0_d;
   logic                psum_q, psum_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // State, counter, latched job parameters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         os_q    <= 1'b0;
         a2b_q   <= 1'b0;
         len_q   <= '0;
         inst_q  <= 3'b000;
         l0_q    <= 1'b0;
         psum_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         os_q    <= os_d;
         a2b_q   <= a2b_d;
         len_q   <= len_d;
         inst_q  <= inst_d;
         l0_q    <= l0_d;
         psum_q  <= psum_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; outputs decoded from next state so they register in step with it
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      os_d    = os_q;
      a2b_d   = a2b_q;
      len_d   = len_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_LOAD;
               os_d    = is_os_in;
               a2b_d   = act_2b_in;
               len_d   = exec_len;
               if (is_os_in)       cnt_d = CNT_W'(row);
               else if (act_2b_in) cnt_d = CNT_W'(2 * col);
               else                cnt_d = CNT_W'(col);
            end
         end
         S_LOAD: begin
            if (cnt_q == CNT_W'(1)) begin
               if (len_q == '0) begin
                  state_d = S_DRAIN;
                  cnt_d   = CNT_W'(row + col - 1);
               end else begin
                  state_d = S_EXEC;
                  cnt_d   = CNT_W'(len_q);
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DRAIN;
               cnt_d   = CNT_W'(row + col - 1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_W'(1)) begin
               if (os_q) begin
                  state_d = S_FLUSH;
                  cnt_d   = CNT_W'(row);
               end else begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end
            end
         end
         S_FLUSH: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      inst_d = 3'b000;
      l0_d   = 1'b0;
      psum_d = 1'b0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      case (state_d)
         S_LOAD: begin
            inst_d = 3'b001;
            l0_d   = 1'b1;
            psum_d = os_d;
         end
         S_EXEC: begin
            inst_d = 3'b010;
            l0_d   = 1'b1;
         end
         S_FLUSH: inst_d = 3'b100;
         default: ;
      endcase
   end

   assign inst_w      = inst_q;
   assign is_os       = os_q;
   assign act_2b_mode = a2b_q;
   assign l0_rd       = l0_q;
   assign psum_rd     = psum_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Bench for mac_array_seq_ctrl: per-cycle output trace built from phase lengths, directed plus random jobs.
module tb_mac_array_seq_ctrl;

   localparam int unsigned ROW = 8;
   localparam int unsigned COL = 8;
   localparam int unsigned LBW = 8;

   typedef logic [6:0] obs_t;  // {inst_w, l0_rd, psum_rd, busy, done}
   localparam obs_t IDLE_O = 7'b0;

   logic           clk = 1'b0;
   logic           reset, start, abort, is_os_in, act_2b_in;
   logic [LBW-1:0] exec_len;
   logic [2:0]     inst_w;
   logic           is_os, act_2b_mode, l0_rd, psum_rd, busy, done;

   int   n_chk, n_bad;
   obs_t trace[$];
   logic exp_os, exp_a2b;

   mac_array_seq_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .is_os_in(is_os_in), .act_2b_in(act_2b_in), .exec_len(exec_len),
      .inst_w(inst_w), .is_os(is_os), .act_2b_mode(act_2b_mode),
      .l0_rd(l0_rd), .psum_rd(psum_rd), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_cycle(input string tag, input obs_t e);
      chk({tag, " outs"}, 32'({inst_w, l0_rd, psum_rd, busy, done}), 32'(e));
      chk({tag, " mode"}, 32'({is_os, act_2b_mode}), 32'({exp_os, exp_a2b}));
   endtask

   function automatic int load_len(input logic os, input logic a2b);
      return os ? int'(ROW) : int'(COL) * (a2b ? 2 : 1);
   endfunction

   // Expected outputs for each cycle after the accepting edge, phase by phase
   task automatic build(input logic os, input logic a2b, input int len);
      trace.delete();
      repeat (load_len(os, a2b)) trace.push_back({3'b001, 1'b1, os, 1'b1, 1'b0});
      repeat (len)               trace.push_back({3'b010, 1'b1, 1'b0, 1'b1, 1'b0});
      repeat (ROW + COL - 1)     trace.push_back({3'b000, 1'b0, 1'b0, 1'b1, 1'b0});
      if (os) repeat (ROW)       trace.push_back({3'b100, 1'b0, 1'b0, 1'b1, 1'b0});
      trace.push_back({3'b000, 1'b0, 1'b0, 1'b1, 1'b1});
   endtask

   task automatic run_job(input string tag, input logic os, input logic a2b, input int len,
                          input int abort_at, input bit noise);
      build(os, a2b, len);
      is_os_in  = os;
      act_2b_in = a2b;
      exec_len  = LBW'(len);
      start     = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      exp_os  = os;
      exp_a2b = a2b;
      for (int i = 0; i < trace.size(); i++) begin
         check_cycle(tag, trace[i]);
         if (noise) begin
            start     = 1'($urandom_range(0, 1));
            is_os_in  = 1'($urandom_range(0, 1));
            act_2b_in = 1'($urandom_range(0, 1));
            exec_len  = LBW'($urandom);
         end
         if (i == abort_at) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            check_cycle({tag, " abort"}, IDLE_O);
            return;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_cycle({tag, " end"}, IDLE_O);
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      is_os_in = 1'b0; act_2b_in = 1'b0; exec_len = '0;
      exp_os = 1'b0; exp_a2b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_cycle("reset", IDLE_O);
      reset = 1'b0;
      @(posedge clk); #1;

      run_job("ws4_len5",    1'b0, 1'b0, 5, -1, 1'b0);
      run_job("ws2_len3",    1'b0, 1'b1, 3, -1, 1'b0);
      run_job("os_len4",     1'b1, 1'b0, 4, -1, 1'b0);
      run_job("ws_len0",     1'b0, 1'b0, 0, -1, 1'b0);
      run_job("abort_exec3", 1'b0, 1'b0, 6, int'(COL) + 2, 1'b0);
      run_job("after_abort", 1'b1, 1'b1, 2, -1, 1'b0);

      // start together with abort in IDLE is dropped; latched mode is kept
      is_os_in = 1'b0; act_2b_in = 1'b0; exec_len = 8'd3;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check_cycle("start_abort_idle", IDLE_O);
      @(posedge clk); #1;
      check_cycle("start_abort_idle2", IDLE_O);

      run_job("ws_noise", 1'b0, 1'b0, 5, -1, 1'b1);
      run_job("os_noise", 1'b1, 1'b1, 7, -1, 1'b1);
      run_job("len_max",  1'b0, 1'b1, 255, -1, 1'b0);

      // reset mid-job clears everything including the latched mode
      is_os_in = 1'b1; act_2b_in = 1'b1; exec_len = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_os = 1'b0; exp_a2b = 1'b0;
      check_cycle("reset_mid", IDLE_O);

      for (int j = 0; j < 25; j++) begin
         logic os, a2b;
         int   len, total, ab;
         os    = 1'($urandom_range(0, 1));
         a2b   = 1'($urandom_range(0, 1));
         len   = int'($urandom_range(0, 12));
         total = load_len(os, a2b) + len + int'(ROW + COL) - 1 + (os ? int'(ROW) : 0) + 1;
         ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
         run_job("rand", os, a2b, len, ab, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
